// File: rtl/encin_pkg.sv
// Shared constants and quadrature step decode for the encoder input path.
package encin_pkg;

  // AB states, written {A,B}, in forward order
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } step_t;

  // Next state in the forward sequence 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      AB_00:   nxt = AB_10;
      AB_10:   nxt = AB_11;
      AB_11:   nxt = AB_01;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

  // Classify a filtered AB change as forward, reverse, illegal or none
  function automatic step_t step_decode(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = '0;
    if ((prev ^ cur) == 2'b11) begin
      s.illegal = 1'b1;
    end else if (cur == fwd_next(prev)) begin
      s.valid = 1'b1;
      s.dir   = DIR_FWD;
    end else if (prev == fwd_next(cur)) begin
      s.valid = 1'b1;
      s.dir   = DIR_REV;
    end
    return s;
  endfunction

endpackage

// File: rtl/encin_sync_filt.sv
// One encoder channel: 2-FF synchroniser, stability filter and prime flag.
module encin_sync_filt #(
  parameter int unsigned FILT_W = 4
) (
  input  logic              i_pclk,
  input  logic              i_prst,
  input  logic              i_pin,
  input  logic [FILT_W-1:0] i_filt_len,
  output logic              o_level,
  output logic              o_primed
);

  logic [1:0]        sync_q;
  // Tracks how far real pin data has propagated since reset, so reset values of
  // the synchroniser are never mistaken for a pin level.
  logic [2:0]        vld_q;
  logic              cand_q;
  logic [FILT_W-1:0] cnt_q;
  logic [FILT_W-1:0] run;
  logic              level_q;
  logic              primed_q;
  logic              accept;

  // Run length of the current synchronised level, saturating
  always_comb begin
    run = '0;
    if (vld_q[2] && (sync_q[1] == cand_q)) begin
      run = (cnt_q == {FILT_W{1'b1}}) ? cnt_q : cnt_q + FILT_W'(1);
    end
    accept = vld_q[1] && (run >= i_filt_len);
  end

  // Synchroniser, stability counter and filtered level
  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      sync_q   <= '0;
      vld_q    <= '0;
      cand_q   <= 1'b0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_pin};
      vld_q  <= {vld_q[1:0], 1'b1};
      if (vld_q[1]) begin
        cand_q <= sync_q[1];
      end
      cnt_q <= run;
      if (accept) begin
        level_q  <= sync_q[1];
        primed_q <= 1'b1;
      end
    end
  end

  assign o_level  = level_q;
  assign o_primed = primed_q;

endmodule

// File: rtl/encin_quad_decoder.sv
// Quadrature encoder input decoder: 4x decode, position count, Z latch, error flag.
module encin_quad_decoder
  import encin_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned FILT_W = 4
) (
  input  logic              i_pclk,
  input  logic              i_prst,
  input  logic              i_enc_a,
  input  logic              i_enc_b,
  input  logic              i_enc_z,
  input  logic              i_enable,
  input  logic [FILT_W-1:0] i_filt_len,
  input  logic              i_clr,
  input  logic              i_z_clr_en,
  input  logic              i_err_clr,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_dir,
  output logic              o_step,
  output logic [CNT_W-1:0]  o_z_latch,
  output logic              o_z_evt,
  output logic              o_err
);

  logic a_lvl, a_prim, b_lvl, b_prim, z_lvl, z_prim;

  encin_sync_filt #(.FILT_W(FILT_W)) u_filt_a (
    .i_pclk     (i_pclk),
    .i_prst     (i_prst),
    .i_pin      (i_enc_a),
    .i_filt_len (i_filt_len),
    .o_level    (a_lvl),
    .o_primed   (a_prim)
  );

  encin_sync_filt #(.FILT_W(FILT_W)) u_filt_b (
    .i_pclk     (i_pclk),
    .i_prst     (i_prst),
    .i_pin      (i_enc_b),
    .i_filt_len (i_filt_len),
    .o_level    (b_lvl),
    .o_primed   (b_prim)
  );

  encin_sync_filt #(.FILT_W(FILT_W)) u_filt_z (
    .i_pclk     (i_pclk),
    .i_prst     (i_prst),
    .i_pin      (i_enc_z),
    .i_filt_len (i_filt_len),
    .o_level    (z_lvl),
    .o_primed   (z_prim)
  );

  logic [1:0]       ab_cur;
  logic [1:0]       prev_ab_q;
  logic             ab_armed_q;
  logic             z_prev_q;
  logic             z_armed_q;
  step_t            st;
  logic             z_rise;
  logic [CNT_W-1:0] stepped;
  logic [CNT_W-1:0] count_d, count_q;
  logic [CNT_W-1:0] zl_d, zl_q;
  logic             dir_q, step_q, z_evt_q, err_q;

  assign ab_cur = {a_lvl, b_lvl};

  // Decode and next-count selection; clear beats Z clear beats step
  always_comb begin
    st = '0;
    if (ab_armed_q) begin
      st = step_decode(prev_ab_q, ab_cur);
    end
    // Armed one cycle after priming, so the priming load itself is never an edge
    z_rise = z_armed_q && z_lvl && !z_prev_q;

    stepped = count_q;
    if (i_enable && st.valid) begin
      stepped = (st.dir == DIR_FWD) ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    end

    count_d = stepped;
    if (i_clr) begin
      count_d = '0;
    end else if (z_rise && i_z_clr_en && i_enable) begin
      count_d = '0;
    end

    zl_d = zl_q;
    if (i_clr) begin
      zl_d = '0;
    end else if (z_rise) begin
      zl_d = stepped;
    end
  end

  // Previous-state tracking, count, latch and registered status outputs
  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      prev_ab_q  <= AB_00;
      ab_armed_q <= 1'b0;
      z_prev_q   <= 1'b0;
      z_armed_q  <= 1'b0;
      count_q    <= '0;
      zl_q       <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      z_evt_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Tracking continues while disabled so re-enable never sees a stale state
      if (a_prim && b_prim) begin
        prev_ab_q <= ab_cur;
      end
      ab_armed_q <= a_prim && b_prim;
      z_prev_q   <= z_lvl;
      z_armed_q  <= z_prim;
      count_q    <= count_d;
      zl_q       <= zl_d;
      step_q     <= i_enable && st.valid;
      if (i_enable && st.valid) begin
        dir_q <= st.dir;
      end
      z_evt_q <= z_rise;
      if (i_enable && st.illegal) begin
        err_q <= 1'b1;
      end else if (i_err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign o_count   = count_q;
  assign o_dir     = dir_q;
  assign o_step    = step_q;
  assign o_z_latch = zl_q;
  assign o_z_evt   = z_evt_q;
  assign o_err     = err_q;

endmodule
